hls_ip_job_sequencer: RTL

HLS_IP_JOB_SEQUENCER -- requirements
Module: hls_ip_job_sequencer

---
 rtl/hls_ip_job_sequencer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/hls_ip_job_sequencer.sv
// Sequences an HLS IP job: one START/COMPUTE/WAIT round per iteration, stepping channel addresses by strides.
// Latency: start_i to first req/engine start pulse is 2 cycles; 3 cycles of overhead per iteration after the done pulses.
// Backpressure: none; done pulses are captured in sticky flags, and start_i is ignored while busy.
module hls_ip_job_sequencer #(
    parameter int CNT_W  = 22,
    parameter int ITER_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              start_i,
    input  logic [ITER_W-1:0] nb_iter_i,
    input  logic [31:0]       in_base_i,
    input  logic [31:0]       out_base_i,
    input  logic [31:0]       in_stride_i,
    input  logic [31:0]       out_stride_i,
    input  logic [CNT_W-1:0]  in_len_i,
    input  logic [CNT_W-1:0]  out_len_i,
    output logic              in_req_start_o,
    output logic              out_req_start_o,
    output logic [31:0]       in_addr_o,
    output logic [31:0]       out_addr_o,
    output logic [CNT_W-1:0]  in_len_o,
    output logic [CNT_W-1:0]  out_len_o,
    input  logic              in_done_i,
    input  logic              out_done_i,
    output logic              engine_start_o,
    output logic              engine_clear_o,
    output logic [ITER_W-1:0] iter_idx_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              cfg_err_o
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        COMPUTE,
        WAIT,
        UPDATEIDX,
        TERMINATE
    } state_t;

    state_t             state_q, state_d;
    logic               in_seen, out_seen;
    logic [ITER_W-1:0]  nb_iter_q;
    logic [31:0]        in_stride_q, out_stride_q;
    logic               cfg_ok;
    logic               last_iter;
    logic               accept;

    always_comb begin
        cfg_ok    = (nb_iter_i != '0) && (in_len_i != '0) && (out_len_i != '0);
        last_iter = (({1'b0, iter_idx_o} + (ITER_W+1)'(1)) == {1'b0, nb_iter_q});
        accept    = (state_q == IDLE) && start_i && cfg_ok;
        state_d   = state_q;
        case (state_q)
            IDLE:      if (accept) state_d = START;
            START:     state_d = COMPUTE;
            COMPUTE:   if (in_seen || in_done_i) state_d = WAIT;
            WAIT:      if (out_seen || out_done_i) state_d = UPDATEIDX;
            UPDATEIDX: state_d = last_iter ? TERMINATE : START;
            TERMINATE: state_d = IDLE;
            default:   state_d = IDLE;
        endcase
        if (clear_i) state_d = IDLE;
    end

    assign busy_o = (state_q != IDLE);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q         <= IDLE;
            in_seen         <= 1'b0;
            out_seen        <= 1'b0;
            nb_iter_q       <= '0;
            in_stride_q     <= '0;
            out_stride_q    <= '0;
            in_addr_o       <= '0;
            out_addr_o      <= '0;
            in_len_o        <= '0;
            out_len_o       <= '0;
            iter_idx_o      <= '0;
            in_req_start_o  <= 1'b0;
            out_req_start_o <= 1'b0;
            engine_start_o  <= 1'b0;
            engine_clear_o  <= 1'b0;
            done_o          <= 1'b0;
            cfg_err_o       <= 1'b0;
        end else begin
            state_q <= state_d;
            // Pulses trail the state by one cycle so they never coincide with done_o
            in_req_start_o  <= (state_q == START) && !clear_i;
            out_req_start_o <= (state_q == START) && !clear_i;
            engine_start_o  <= (state_q == START) && !clear_i;
            engine_clear_o  <= clear_i;
            done_o          <= (state_q == TERMINATE) && !clear_i;
            cfg_err_o       <= (state_q == IDLE) && start_i && !cfg_ok && !clear_i;

            if (clear_i) begin
                in_seen    <= 1'b0;
                out_seen   <= 1'b0;
                iter_idx_o <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (accept) begin
                            nb_iter_q    <= nb_iter_i;
                            in_stride_q  <= in_stride_i;
                            out_stride_q <= out_stride_i;
                            in_addr_o    <= in_base_i;
                            out_addr_o   <= out_base_i;
                            in_len_o     <= in_len_i;
                            out_len_o    <= out_len_i;
                            iter_idx_o   <= '0;
                            in_seen      <= 1'b0;
                            out_seen     <= 1'b0;
                        end
                    end
                    COMPUTE, WAIT: begin
                        if (in_done_i)  in_seen  <= 1'b1;
                        if (out_done_i) out_seen <= 1'b1;
                    end
                    UPDATEIDX: begin
                        if (!last_iter) begin
                            iter_idx_o <= iter_idx_o + ITER_W'(1);
                            in_addr_o  <= in_addr_o + in_stride_q;
                            out_addr_o <= out_addr_o + out_stride_q;
                            in_seen    <= 1'b0;
                            out_seen   <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
